// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the multi-cycle shift sequencer: widths, shift codes
// and FSM state encoding.
package shift_sequencer_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/busy/done request bus of the shift sequencer; the datapath is the
// master, the sequencer is the slave.
interface shift_sequencer_if
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = AMT_W
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [CNT_W-1:0] i_amount;
    logic [WIDTH-1:0] i_in;
    logic [1:0]       o_shift_code;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_out;

    modport master (
        output i_start, i_op, i_amount, i_in,
        input  o_shift_code, o_busy, o_done, o_out
    );

    modport slave (
        input  i_start, i_op, i_amount, i_in,
        output o_shift_code, o_busy, o_done, o_out
    );
endinterface

// File: rtl/shift_sequencer_step.sv
// Combinational single-step shifter: applies one 2-bit shift code to a word.
// Bits shifted out are discarded; code 00 passes the operand through.
module shift_sequencer_step
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [1:0]       i_shift,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_out
);

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        o_out = i_in;
        case (i_shift)
            SH_LSL:  o_out = {i_in[WIDTH-2:0], 1'b0};
            SH_LSR:  o_out = {1'b0, i_in[WIDTH-1:1]};
            SH_ASR:  o_out = {i_in[WIDTH-1], i_in[WIDTH-1:1]};
            default: o_out = i_in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: latches an operand and shifts it one position per
// clock for `amount` cycles, then pulses done with the result held in o_out.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = AMT_W
) (
    input  logic            clk,
    input  logic            reset,
    shift_sequencer_if.slave bus
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_out;

    logic [1:0]       w_shift_code;
    logic [WIDTH-1:0] w_step_out;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_accept;
    logic             w_no_work;

    assign w_accept  = (r_state == ST_IDLE) && bus.i_start;
    assign w_no_work = (bus.i_amount == '0) || (bus.i_op == SH_NONE);

    // Shift code is NONE outside SHIFT, so the step output equals r_acc there.
    shift_sequencer_step #(.WIDTH(WIDTH)) u_step (
        .i_shift (w_shift_code),
        .i_in    (r_acc),
        .o_out   (w_step_out)
    );

    assign w_acc_next = w_accept ? bus.i_in : w_step_out;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_next_state = w_no_work ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_shift_code = (r_state == ST_SHIFT) ? r_op : SH_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_op  <= SH_NONE;
            r_out <= '0;
        end else begin
            r_acc <= w_acc_next;
            if (w_accept) begin
                r_op  <= bus.i_op;
                r_cnt <= bus.i_amount;
            end else if (r_state == ST_SHIFT) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // Result register loads only on the edge that enters DONE.
            if ((w_next_state == ST_DONE) && (r_state != ST_DONE)) begin
                r_out <= w_acc_next;
            end
        end
    end

    assign bus.o_shift_code = w_shift_code;
    assign bus.o_busy       = (r_state != ST_IDLE);
    assign bus.o_done       = (r_state == ST_DONE);
    assign bus.o_out        = r_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed corner cases plus random
// operations compared against an arithmetic shift model.
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [15:0] model_out;

    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(16), .CNT_W(4)) bus ();

    shift_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [1:0] o, input int n);
        logic signed [15:0] s;
        s = a;
        case (o)
            2'b01:   return a << n;
            2'b10:   return a >> n;
            2'b11:   return s >>> n;
            default: return a;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation (start asserted now, accepted at the next edge) and
    // checks every cycle until the IDLE cycle following done.
    task automatic run_op(input logic [15:0] a, input logic [1:0] o, input logic [3:0] n, input bit pulse);
        int          s;
        logic [15:0] exp;
        s   = (n == 4'd0 || o == 2'b00) ? 0 : int'(n);
        exp = ref_shift(a, o, int'(n));
        bus.i_start  = 1'b1;
        bus.i_in     = a;
        bus.i_op     = o;
        bus.i_amount = n;
        tick();
        bus.i_start  = 1'b0;
        bus.i_in     = 16'($urandom);
        bus.i_op     = 2'($urandom);
        bus.i_amount = 4'($urandom);
        for (int j = 0; j < s; j++) begin
            check("shift_busy", bus.o_busy, 1);
            check("shift_code", bus.o_shift_code, o);
            check("shift_no_done", bus.o_done, 0);
            check("shift_out_hold", bus.o_out, model_out);
            if (pulse && j == s / 2) begin
                bus.i_start = 1'b1;
                bus.i_in    = 16'hFFFF;
            end else begin
                bus.i_start = 1'b0;
            end
            tick();
        end
        bus.i_start = 1'b0;
        check("done_pulse", bus.o_done, 1);
        check("done_busy", bus.o_busy, 1);
        check("done_code", bus.o_shift_code, 0);
        check("done_out", bus.o_out, exp);
        model_out = exp;
        tick();
        check("idle_done_low", bus.o_done, 0);
        check("idle_busy_low", bus.o_busy, 0);
        check("idle_out_hold", bus.o_out, model_out);
    endtask

    task automatic idle_gap(input int g);
        for (int k = 0; k < g; k++) begin
            tick();
            check("gap_busy", bus.o_busy, 0);
            check("gap_out", bus.o_out, model_out);
        end
    endtask

    initial begin
        bus.i_start  = 1'b0;
        bus.i_in     = '0;
        bus.i_op     = '0;
        bus.i_amount = '0;
        model_out    = '0;
        reset        = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_busy", bus.o_busy, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_out", bus.o_out, 0);
        check("rst_code", bus.o_shift_code, 0);
        idle_gap(2);

        run_op(16'h0001, 2'b01, 4'd4, 1'b0);
        check("lsl4_const", bus.o_out, 16'h0010);
        run_op(16'h8000, 2'b11, 4'd15, 1'b0);
        check("asr15_const", bus.o_out, 16'hFFFF);
        run_op(16'h8000, 2'b10, 4'd3, 1'b0);
        check("lsr3_const", bus.o_out, 16'h1000);
        run_op(16'h0001, 2'b01, 4'd15, 1'b0);
        check("lsl15_const", bus.o_out, 16'h8000);
        run_op(16'hABCD, 2'b01, 4'd0, 1'b0);
        check("amt0_const", bus.o_out, 16'hABCD);
        run_op(16'h1234, 2'b00, 4'd7, 1'b0);
        check("op00_const", bus.o_out, 16'h1234);
        // Busy start pulse ignored; the next operation starts back-to-back.
        run_op(16'h00A5, 2'b01, 4'd8, 1'b1);
        check("ignore_start_const", bus.o_out, 16'hA500);
        run_op(16'hF00F, 2'b11, 4'd2, 1'b0);
        check("b2b_const", bus.o_out, 16'hFC03);

        // Reset two steps into a ten-step operation aborts it without done.
        bus.i_start  = 1'b1;
        bus.i_in     = 16'h0F0F;
        bus.i_op     = 2'b01;
        bus.i_amount = 4'd10;
        tick();
        bus.i_start = 1'b0;
        tick();
        tick();
        check("pre_abort_busy", bus.o_busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_out = '0;
        check("abort_busy", bus.o_busy, 0);
        check("abort_done", bus.o_done, 0);
        check("abort_out", bus.o_out, 0);
        check("abort_code", bus.o_shift_code, 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("abort_no_done", bus.o_done, 0);
        end

        for (int t = 0; t < 40; t++) begin
            run_op(16'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));
            idle_gap(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
